csa_stream_accumulator: RTL and testbench
=========================================

# csa_stream_accumulator

Parametrised streaming accumulator that keeps its running total in carry-save form. Each accepted beat carries two operands, which are folded into the redundant (sum, carry) state through one 4:2 compression per cycle. When the last beat of a packet arrives, a multi-cycle chunked carry-propagate adder resolves the total. It sits in the SFU datapath behind producers that emit operand pairs, and replaces ad-hoc adder chains for reductions of up to MAX_BEATS beats.

## Interface

Clock is `clk_i`; reset is `rst_i`, synchronous and active-high.

- OP_WIDTH, 32, width of each input operand
- MAX_BEATS, 128, beats per packet guaranteed without overflow
- ACC_WIDTH, OP_WIDTH+$clog2(2*MAX_BEATS) (default 40), accumulator/result width
- CPA_CHUNK, 16, bits resolved per RESOLVE cycle; 1 ≤ CPA_CHUNK ≤ ACC_WIDTH
- NUM_CHUNKS, ceil(ACC_WIDTH/CPA_CHUNK) (default 3), derived, not overridable

- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  beat valid
- in_ready_o  out  1  beat accepted when valid&&ready
- in_op_a_i  in  OP_WIDTH  operand A
- in_op_b_i  in  OP_WIDTH  operand B
- in_signed_i  in  1  1 = two's-complement operands; sampled on first beat only
- in_last_i  in  1  final beat of packet
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result consumed when valid&&ready
- out_sum_o  out  ACC_WIDTH  resolved total mod 2^ACC_WIDTH
- out_count_o  out  $clog2(MAX_BEATS+1)+1  beats in packet, saturating at all-ones
- out_overflow_o  out  1  packet exceeded MAX_BEATS beats

## Operation

- States: ACC, RESOLVE, DONE. Reset enters ACC.
- ACC:
  - in_ready_o=1.
  - On a handshake, each operand is sign-extended (latched signed=1) or zero-extended to ACC_WIDTH.
  - (S, C) ← compress42(S, C, ext_a, ext_b). New carry vector = carries<<1, truncated to ACC_WIDTH; the bit shifted out is discarded (mod 2^ACC_WIDTH arithmetic).
  - count increments, saturating.
  - A beat accepted while count == MAX_BEATS sets sticky overflow.
  - The first beat of a packet (count==0) latches in_signed_i.
  - in_last_i on a handshake → RESOLVE with chunk index k=0 and carry=0.
- RESOLVE:
  - in_ready_o=0.
  - Each cycle: result[k] = S[k] + C[k] + carry, on CPA_CHUNK bits; the final chunk may be partial. Store it and keep the carry-out.
  - After k = NUM_CHUNKS-1 → DONE. Final carry-out discarded.
- DONE:
  - out_valid_o=1, in_ready_o=0.
  - out_sum_o, out_count_o and out_overflow_o are held stable until out_ready_i.
  - On that handshake: clear S, C, count, overflow; → ACC.
- in_valid_i is ignored outside ACC. No beat is accepted in the DONE cycle in which the output handshake occurs.
- Outputs are registered. out_sum_o is valid only while out_valid_o=1 but is driven from the result register at all times.
- Reset at any time (including mid-RESOLVE or in DONE with out_ready_i low):
  - Aborts the packet.
  - Next cycle: state ACC, in_ready_o=1, out_valid_o=0, out_sum_o=0, out_count_o=0, out_overflow_o=0, S=C=0.

## Timing

- Throughput: one beat per cycle in ACC, no bubbles between beats.
- Latency: last beat accepted at edge t → RESOLVE occupies cycles t+1..t+NUM_CHUNKS → out_valid_o high from cycle t+NUM_CHUNKS+1. Default: 4 cycles after the last-beat cycle.
- Packet-to-packet minimum: NUM_CHUNKS+1 cycles of in_ready_o=0 after each last beat, with immediate out_ready_i.
- Critical path: one 4:2 compressor level plus extension in ACC; one CPA_CHUNK-bit adder in RESOLVE.

## Test plan

- Unsigned single beat: a=5, b=7, last=1 → out_valid 4 cycles later, sum=12, count=1, overflow=0.
- Signed multi-beat: 3 beats of (0xFFFFFFFF, 0xFFFFFFFF), signed=1 → sum=0xFF_FFFF_FFFA (−6), count=3. A repeat with signed toggled on beats 2–3 gives the same result.
- Cross-chunk carries: 128 beats of (0xFFFFFFFF, 0xFFFFFFFF), unsigned → sum=0xFF_FFFF_FF00, count=128, overflow=0.
- Overflow: 129 beats of (1, 0) → sum=129, overflow=1, count=129.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE → outputs stable, in_ready_o=0, in_valid_i ignored. After the handshake, in_ready_o=1 on the next cycle and the next packet starts from zero.
- Reset mid-RESOLVE (cycle t+2) → next cycle out_valid_o=0, in_ready_o=1. A following packet (10, 20) gives sum=30.

Source files
------------

// File: rtl/csa_stream_accumulator_if.sv
// Operand-pair input stream and resolved-total output stream of the carry-save accumulator.
// The master side is the producer/consumer; the slave side is the accumulator.
interface csa_stream_accumulator_if #(
  parameter int OP_WIDTH  = 32,
  parameter int MAX_BEATS = 128,
  parameter int ACC_WIDTH = OP_WIDTH + $clog2(2 * MAX_BEATS),
  parameter int CNT_WIDTH = $clog2(MAX_BEATS + 1) + 1
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [OP_WIDTH-1:0]  in_op_a_i;
  logic [OP_WIDTH-1:0]  in_op_b_i;
  logic                 in_signed_i;
  logic                 in_last_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [ACC_WIDTH-1:0] out_sum_o;
  logic [CNT_WIDTH-1:0] out_count_o;
  logic                 out_overflow_o;

  modport master (
    output in_valid_i, in_op_a_i, in_op_b_i, in_signed_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_sum_o, out_count_o, out_overflow_o
  );

  modport slave (
    input  in_valid_i, in_op_a_i, in_op_b_i, in_signed_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, out_sum_o, out_count_o, out_overflow_o
  );
endinterface

// File: rtl/csa_stream_accumulator.sv
// Streaming accumulator holding its running total in carry-save form; a chunked
// carry-propagate adder resolves the total over NUM_CHUNKS cycles after the last beat.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ACC     | accepting beats, folding operand pairs into (sum, carry)
// ST_RESOLVE | propagating carries one CPA_CHUNK-bit slice per cycle
// ST_DONE    | result presented, waiting for the output handshake
module csa_stream_accumulator #(
  parameter int OP_WIDTH  = 32,
  parameter int MAX_BEATS = 128,
  parameter int ACC_WIDTH = OP_WIDTH + $clog2(2 * MAX_BEATS),
  parameter int CPA_CHUNK = 16
) (
  input logic clk_i,
  input logic rst_i,
  csa_stream_accumulator_if.slave bus
);
  localparam int NUM_CHUNKS = (ACC_WIDTH + CPA_CHUNK - 1) / CPA_CHUNK;
  localparam int CNT_WIDTH  = $clog2(MAX_BEATS + 1) + 1;
  localparam int IDX_WIDTH  = $clog2(NUM_CHUNKS + 1);
  localparam int LO_WIDTH   = $clog2(ACC_WIDTH + 1);
  localparam int EXT_WIDTH  = ACC_WIDTH - OP_WIDTH;

  typedef enum logic [1:0] {
    ST_ACC,
    ST_RESOLVE,
    ST_DONE
  } state_t;

  state_t state, state_next;

  logic [ACC_WIDTH-1:0] sum_vec, carry_vec, result;
  logic [CNT_WIDTH-1:0] count;
  logic                 overflow;
  logic                 signed_lat;
  logic [IDX_WIDTH-1:0] chunk_idx;
  logic [LO_WIDTH-1:0]  chunk_lo;
  logic                 cpa_carry;

  logic                 in_ready, out_valid;
  logic                 beat_fire, out_fire, last_chunk, beat_signed;
  logic [ACC_WIDTH-1:0] ext_a, ext_b, csa_t, csa_m, sum_next, carry_next;
  logic [CPA_CHUNK:0]   chunk_sum;

  // Two stacked 3:2 stages form the 4:2 compression; bits shifted past the top are dropped.
  always_comb begin
    beat_signed = (count == '0) ? bus.in_signed_i : signed_lat;
    ext_a       = {{EXT_WIDTH{beat_signed & bus.in_op_a_i[OP_WIDTH-1]}}, bus.in_op_a_i};
    ext_b       = {{EXT_WIDTH{beat_signed & bus.in_op_b_i[OP_WIDTH-1]}}, bus.in_op_b_i};
    csa_t       = sum_vec ^ carry_vec ^ ext_a;
    csa_m       = ((sum_vec & carry_vec) | (sum_vec & ext_a) | (carry_vec & ext_a)) << 1;
    sum_next    = csa_t ^ csa_m ^ ext_b;
    carry_next  = ((csa_t & csa_m) | (csa_t & ext_b) | (csa_m & ext_b)) << 1;
    chunk_sum   = {1'b0, sum_vec[CPA_CHUNK-1:0]} + {1'b0, carry_vec[CPA_CHUNK-1:0]}
                + {{CPA_CHUNK{1'b0}}, cpa_carry};
  end

  assign last_chunk = (chunk_idx == IDX_WIDTH'(NUM_CHUNKS - 1));
  assign beat_fire  = in_ready & bus.in_valid_i;
  assign out_fire   = out_valid & bus.out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_ACC;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_ACC: begin
        in_ready = 1'b1;
        if (bus.in_valid_i && bus.in_last_i) state_next = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (last_chunk) state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready_i) state_next = ST_ACC;
      end
      default: state_next = ST_ACC;
    endcase
  end

  // During RESOLVE the (sum, carry) pair is shifted down so the low slice is always the next chunk.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_vec    <= '0;
      carry_vec  <= '0;
      result     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      signed_lat <= 1'b0;
      chunk_idx  <= '0;
      chunk_lo   <= '0;
      cpa_carry  <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (beat_fire) begin
            sum_vec   <= sum_next;
            carry_vec <= carry_next;
            if (count != '1) count <= count + 1'b1;
            if (count == CNT_WIDTH'(MAX_BEATS)) overflow <= 1'b1;
            if (count == '0) signed_lat <= bus.in_signed_i;
            if (bus.in_last_i) begin
              chunk_idx <= '0;
              chunk_lo  <= '0;
              cpa_carry <= 1'b0;
              result    <= '0;
            end
          end
        end
        ST_RESOLVE: begin
          sum_vec   <= sum_vec >> CPA_CHUNK;
          carry_vec <= carry_vec >> CPA_CHUNK;
          result    <= result | (ACC_WIDTH'(chunk_sum[CPA_CHUNK-1:0]) << chunk_lo);
          cpa_carry <= chunk_sum[CPA_CHUNK];
          chunk_idx <= chunk_idx + 1'b1;
          chunk_lo  <= chunk_lo + LO_WIDTH'(CPA_CHUNK);
        end
        ST_DONE: begin
          if (out_fire) begin
            sum_vec   <= '0;
            carry_vec <= '0;
            count     <= '0;
            overflow  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready_o     = in_ready;
  assign bus.out_valid_o    = out_valid;
  assign bus.out_sum_o      = result;
  assign bus.out_count_o    = count;
  assign bus.out_overflow_o = overflow;
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Self-checking bench for csa_stream_accumulator: directed scenarios plus randomized
// packets compared against an arithmetic reference sum.
module tb_csa_stream_accumulator;
  localparam int OPW   = 32;
  localparam int MAXB  = 128;
  localparam int ACCW  = 40;
  localparam int CNTW  = 9;
  localparam int CHUNK = 16;
  localparam int NCH   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csa_stream_accumulator_if #(.OP_WIDTH(OPW), .MAX_BEATS(MAXB)) bus ();

  csa_stream_accumulator #(
    .OP_WIDTH(OPW), .MAX_BEATS(MAXB), .CPA_CHUNK(CHUNK)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  bit          q_s[$];

  function automatic logic [63:0] ext64(input logic [31:0] v, input bit s);
    return s ? {{32{v[31]}}, v} : {32'h0, v};
  endfunction

  function automatic logic [ACCW-1:0] model_sum();
    logic [63:0] acc;
    acc = '0;
    foreach (q_a[i]) acc = acc + ext64(q_a[i], q_s[0]) + ext64(q_b[i], q_s[0]);
    return acc[ACCW-1:0];
  endfunction

  function automatic logic [CNTW-1:0] model_count();
    int n;
    n = q_a.size();
    return (n >= 511) ? 9'h1FF : CNTW'(n);
  endfunction

  function automatic bit model_ovf();
    return q_a.size() > MAXB;
  endfunction

  task automatic clear_q();
    q_a.delete(); q_b.delete(); q_s.delete();
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [31:0] b, input bit s);
    q_a.push_back(a); q_b.push_back(b); q_s.push_back(s);
  endtask

  task automatic drive_idle();
    bus.in_valid_i  = 1'b0;
    bus.in_op_a_i   = '0;
    bus.in_op_b_i   = '0;
    bus.in_signed_i = 1'b0;
    bus.in_last_i   = 1'b0;
  endtask

  // Sends the queued packet; returns at the negedge after the last beat's accepting edge.
  task automatic send_queued(input int gap_max);
    int guard;
    for (int i = 0; i < q_a.size(); i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          bus.in_valid_i = 1'b0;
          @(negedge clk);
        end
      end
      bus.in_valid_i  = 1'b1;
      bus.in_op_a_i   = q_a[i];
      bus.in_op_b_i   = q_b[i];
      bus.in_signed_i = q_s[i];
      bus.in_last_i   = (i == q_a.size() - 1);
      guard = 0;
      while (bus.in_ready_o !== 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        checks++; failures++;
        $display("FAIL beat_accept_timeout beat=%0d waited=%0d", i, guard);
      end
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic wait_out_valid(output int cycles);
    cycles = 1;
    while (bus.out_valid_o !== 1'b1 && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic consume(input int delay);
    repeat (delay) @(negedge clk);
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bus.out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready_o); end
    checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid_o); end
    checks++; if (bus.out_sum_o !== '0) begin failures++; $display("FAIL reset_sum got=%h exp=0", bus.out_sum_o); end
    checks++; if (bus.out_count_o !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.out_count_o); end
    checks++; if (bus.out_overflow_o !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.out_overflow_o); end
  endtask

  task automatic test_single_beat();
    int lat;
    clear_q();
    push_beat(32'd5, 32'd7, 1'b0);
    send_queued(0);
    wait_out_valid(lat);
    checks++; if (lat != NCH + 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", lat, NCH + 1); end
    checks++; if (bus.out_sum_o !== 40'd12) begin failures++; $display("FAIL single_sum got=%h exp=%h", bus.out_sum_o, 40'd12); end
    checks++; if (bus.out_count_o !== 9'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bus.out_count_o); end
    checks++; if (bus.out_overflow_o !== 1'b0) begin failures++; $display("FAIL single_overflow got=%b exp=0", bus.out_overflow_o); end
    consume(0);
  endtask

  task automatic test_signed_multi();
    int lat;
    for (int rep = 0; rep < 2; rep++) begin
      clear_q();
      for (int i = 0; i < 3; i++) push_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, (rep == 0) ? 1'b1 : (i == 0));
      send_queued(0);
      wait_out_valid(lat);
      checks++; if (bus.out_sum_o !== 40'hFF_FFFF_FFFA) begin failures++; $display("FAIL signed_sum rep=%0d got=%h exp=%h", rep, bus.out_sum_o, 40'hFF_FFFF_FFFA); end
      checks++; if (bus.out_sum_o !== model_sum()) begin failures++; $display("FAIL signed_model rep=%0d got=%h exp=%h", rep, bus.out_sum_o, model_sum()); end
      checks++; if (bus.out_count_o !== 9'd3) begin failures++; $display("FAIL signed_count rep=%0d got=%0d exp=3", rep, bus.out_count_o); end
      consume(0);
    end
  endtask

  task automatic test_cross_chunk();
    int lat;
    clear_q();
    for (int i = 0; i < 128; i++) push_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    send_queued(0);
    wait_out_valid(lat);
    checks++; if (bus.out_sum_o !== 40'hFF_FFFF_FF00) begin failures++; $display("FAIL cross_sum got=%h exp=%h", bus.out_sum_o, 40'hFF_FFFF_FF00); end
    checks++; if (bus.out_count_o !== 9'd128) begin failures++; $display("FAIL cross_count got=%0d exp=128", bus.out_count_o); end
    checks++; if (bus.out_overflow_o !== 1'b0) begin failures++; $display("FAIL cross_overflow got=%b exp=0", bus.out_overflow_o); end
    consume(0);
  endtask

  task automatic test_overflow();
    int lat;
    clear_q();
    for (int i = 0; i < 129; i++) push_beat(32'd1, 32'd0, 1'b0);
    send_queued(0);
    wait_out_valid(lat);
    checks++; if (bus.out_sum_o !== 40'd129) begin failures++; $display("FAIL ovf_sum got=%h exp=%h", bus.out_sum_o, 40'd129); end
    checks++; if (bus.out_count_o !== 9'd129) begin failures++; $display("FAIL ovf_count got=%0d exp=129", bus.out_count_o); end
    checks++; if (bus.out_overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus.out_overflow_o); end
    consume(0);
  endtask

  task automatic test_backpressure();
    int lat;
    clear_q();
    push_beat(32'd100, 32'd200, 1'b0);
    send_queued(0);
    wait_out_valid(lat);
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid_i = 1'b1;
      bus.in_op_a_i  = $urandom;
      bus.in_op_b_i  = $urandom;
      bus.in_last_i  = 1'b1;
      @(negedge clk);
      checks++; if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, bus.out_valid_o); end
      checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready_o); end
      checks++; if (bus.out_sum_o !== 40'd300) begin failures++; $display("FAIL bp_sum cyc=%0d got=%h exp=%h", i, bus.out_sum_o, 40'd300); end
      checks++; if (bus.out_count_o !== 9'd1) begin failures++; $display("FAIL bp_count cyc=%0d got=%0d exp=1", i, bus.out_count_o); end
    end
    drive_idle();
    consume(0);
    checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%b exp=1", bus.in_ready_o); end
    checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL bp_valid_after got=%b exp=0", bus.out_valid_o); end
    clear_q();
    push_beat(32'd3, 32'd4, 1'b0);
    send_queued(0);
    wait_out_valid(lat);
    checks++; if (bus.out_sum_o !== 40'd7) begin failures++; $display("FAIL bp_next_sum got=%h exp=%h", bus.out_sum_o, 40'd7); end
    checks++; if (bus.out_count_o !== 9'd1) begin failures++; $display("FAIL bp_next_count got=%0d exp=1", bus.out_count_o); end
    consume(0);
  endtask

  task automatic test_back_to_back();
    int stalls;
    bit got_valid;
    logic [ACCW-1:0] got_sum, exp_sum;
    bus.out_ready_i = 1'b1;
    for (int p = 0; p < 2; p++) begin
      clear_q();
      push_beat($urandom, $urandom, 1'($urandom_range(1, 0)));
      push_beat($urandom, $urandom, 1'b0);
      exp_sum = model_sum();
      send_queued(0);
      stalls = 0;
      got_valid = 1'b0;
      got_sum = '0;
      while (bus.in_ready_o !== 1'b1 && stalls < 50) begin
        if (bus.out_valid_o === 1'b1) begin
          got_valid = 1'b1;
          got_sum = bus.out_sum_o;
        end
        @(negedge clk);
        stalls++;
      end
      checks++; if (stalls != NCH + 1) begin failures++; $display("FAIL b2b_stall pkt=%0d got=%0d exp=%0d", p, stalls, NCH + 1); end
      checks++; if (!got_valid || got_sum !== exp_sum) begin failures++; $display("FAIL b2b_sum pkt=%0d got=%h valid=%b exp=%h", p, got_sum, got_valid, exp_sum); end
    end
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_resolve();
    int lat;
    clear_q();
    push_beat(32'd7, 32'd9, 1'b0);
    send_queued(0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", bus.out_valid_o); end
    checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL rst_res_ready got=%b exp=1", bus.in_ready_o); end
    checks++; if (bus.out_count_o !== '0) begin failures++; $display("FAIL rst_res_count got=%0d exp=0", bus.out_count_o); end
    send_queued(0);
    wait_out_valid(lat);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.out_sum_o !== '0) begin failures++; $display("FAIL rst_done_sum got=%h exp=0", bus.out_sum_o); end
    checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_done_valid got=%b exp=0", bus.out_valid_o); end
    clear_q();
    push_beat(32'd10, 32'd20, 1'b0);
    send_queued(0);
    wait_out_valid(lat);
    checks++; if (bus.out_sum_o !== 40'd30) begin failures++; $display("FAIL rst_after_sum got=%h exp=%h", bus.out_sum_o, 40'd30); end
    checks++; if (bus.out_count_o !== 9'd1) begin failures++; $display("FAIL rst_after_count got=%0d exp=1", bus.out_count_o); end
    consume(0);
  endtask

  task automatic test_random();
    int lat, n;
    for (int p = 0; p < 20; p++) begin
      clear_q();
      n = ($urandom_range(7, 0) == 0) ? $urandom_range(135, 125) : $urandom_range(6, 1);
      for (int i = 0; i < n; i++) push_beat($urandom, $urandom, 1'($urandom_range(1, 0)));
      send_queued(2);
      wait_out_valid(lat);
      checks++; if (lat >= 300) begin failures++; $display("FAIL rnd_timeout pkt=%0d waited=%0d", p, lat); end
      checks++; if (bus.out_sum_o !== model_sum()) begin failures++; $display("FAIL rnd_sum pkt=%0d got=%h exp=%h", p, bus.out_sum_o, model_sum()); end
      checks++; if (bus.out_count_o !== model_count()) begin failures++; $display("FAIL rnd_count pkt=%0d got=%0d exp=%0d", p, bus.out_count_o, model_count()); end
      checks++; if (bus.out_overflow_o !== model_ovf()) begin failures++; $display("FAIL rnd_overflow pkt=%0d got=%b exp=%b", p, bus.out_overflow_o, model_ovf()); end
      consume($urandom_range(3, 0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    bus.out_ready_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_beat();
    test_signed_multi();
    test_cross_chunk();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_resolve();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
